// File: rtl/dh_modexp_slave.sv
`default_nettype none
// dh_modexp_slave (rev 1.0): DH register window with a bit-serial BASE^EXP mod MOD engine.
// Define DH_CYCLE_COUNTER_EN to add the read-only CYCLES register at offset 0x30.
module dh_modexp_slave #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  input  logic [7:0]        be_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [63:0]       rdata_o,
  output logic              err_o,
  output logic              irq_o
);

  localparam int IW = ADDR_W - 3;
  localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [IW-1:0] c_idx_ctrl   = IW'(0);
  localparam logic [IW-1:0] c_idx_status = IW'(1);
  localparam logic [IW-1:0] c_idx_base   = IW'(2);
  localparam logic [IW-1:0] c_idx_exp    = IW'(3);
  localparam logic [IW-1:0] c_idx_mod    = IW'(4);
  localparam logic [IW-1:0] c_idx_result = IW'(5);
  localparam logic [JW-1:0] c_j_last     = JW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_BIT   = 3'd2,
    S_MUL_R = 3'd3,
    S_MUL_B = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t             r_state, w_state_nx;
  logic               r_irq_en, r_done, r_err, r_irq;
  logic [WIDTH-1:0]   r_base, r_exp, r_mod, r_result;
  logic [WIDTH-1:0]   r_racc, r_bacc, r_p;
  logic [JW-1:0]      r_j, r_k;
  logic               r_rvalid, r_rerr;
  logic [63:0]        r_rdata;

  function automatic logic [63:0] merge_be(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

`ifdef DH_CYCLE_COUNTER_EN
  localparam logic [IW-1:0] c_idx_cycles = IW'(6);
  logic [63:0] r_cycles;
`endif

  // ---------------- bus decode ----------------
  logic [IW-1:0] w_idx;
  logic          w_busy, w_mapped;
  logic          w_hit_ctrl, w_hit_status, w_hit_op;
  logic          w_start_bit, w_busy_err, w_acc_err, w_wr_ok;
  logic          w_start, w_clr_done, w_clr_err;
  logic [63:0]   w_rdata, w_wmerged;
  logic          w_unused_ok;

  assign w_idx        = addr_i[ADDR_W-1:3];
  assign w_busy       = (r_state != S_IDLE);
  assign w_hit_ctrl   = (w_idx == c_idx_ctrl);
  assign w_hit_status = (w_idx == c_idx_status);
  assign w_hit_op     = (w_idx == c_idx_base) | (w_idx == c_idx_exp) | (w_idx == c_idx_mod);
  assign w_unused_ok  = &{1'b0, addr_i[2:0]};

  always_comb begin
    w_mapped = 1'b1;
    w_rdata  = '0;
    case (w_idx)
      c_idx_ctrl:   w_rdata = {62'd0, r_irq_en, 1'b0};
      c_idx_status: w_rdata = {61'd0, r_err, r_done, w_busy};
      c_idx_base:   w_rdata = 64'(r_base);
      c_idx_exp:    w_rdata = 64'(r_exp);
      c_idx_mod:    w_rdata = 64'(r_mod);
      c_idx_result: w_rdata = 64'(r_result);
`ifdef DH_CYCLE_COUNTER_EN
      c_idx_cycles: w_rdata = r_cycles;
`endif
      default:      w_mapped = 1'b0;
    endcase
  end

  // Operand and START writes are rejected while the engine owns the operands.
  assign w_start_bit = be_i[0] & wdata_i[0];
  assign w_busy_err  = we_i & w_busy & (w_hit_op | (w_hit_ctrl & w_start_bit));
  assign w_acc_err   = req_i & (~w_mapped | w_busy_err);
  assign w_wr_ok     = req_i & we_i & w_mapped & ~w_busy_err;
  assign w_start     = w_wr_ok & w_hit_ctrl & w_start_bit;
  assign w_clr_done  = w_wr_ok & w_hit_status & be_i[0] & wdata_i[1];
  assign w_clr_err   = w_wr_ok & w_hit_status & be_i[0] & wdata_i[2];
  assign w_wmerged   = merge_be(w_rdata, wdata_i, be_i);

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_rerr;
  assign irq_o    = r_irq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rerr   <= w_acc_err;
      r_rdata  <= (req_i & ~we_i & w_mapped) ? w_rdata : 64'd0;
    end
  end

  // ---------------- engine control ----------------
  logic             w_chk_bad, w_mul_last, w_mul_bit;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH:0]   w_mod_x, w_p2, w_p2r, w_p3, w_p_nx;
  logic             w_set_done, w_set_err;

  assign w_chk_bad  = (r_mod == '0) | (r_base >= r_mod);
  assign w_mul_last = (r_k == c_j_last);
  assign w_set_err  = (r_state == S_CHECK) & w_chk_bad;
  assign w_set_done = w_set_err | (r_state == S_FIN);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_CHECK;
      S_CHECK: w_state_nx = w_chk_bad ? S_IDLE : S_BIT;
      S_BIT:   w_state_nx = r_exp[r_j] ? S_MUL_R : S_MUL_B;
      S_MUL_R: if (w_mul_last) w_state_nx = S_MUL_B;
      S_MUL_B: if (w_mul_last) w_state_nx = (r_j == c_j_last) ? S_FIN : S_BIT;
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Interleaved MSB-first modular multiply: A * r_bacc mod MOD, one multiplier bit per cycle.
  assign w_mul_a = (r_state == S_MUL_R) ? r_racc : r_bacc;
  assign w_mul_bit = r_bacc[c_j_last - r_k];
  assign w_mod_x = {1'b0, r_mod};
  assign w_p2    = {r_p, 1'b0};
  assign w_p2r   = (w_p2 >= w_mod_x) ? (w_p2 - w_mod_x) : w_p2;
  assign w_p3    = w_p2r + {1'b0, w_mul_a};
  assign w_p_nx  = w_mul_bit ? ((w_p3 >= w_mod_x) ? (w_p3 - w_mod_x) : w_p3) : w_p2r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_racc   <= '0;
      r_bacc   <= '0;
      r_p      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_chk_bad) begin
            r_result <= '0;
          end else begin
            r_racc <= (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_bacc <= r_base;
            r_j    <= '0;
          end
        end
        S_BIT: begin
          r_p <= '0;
          r_k <= '0;
        end
        S_MUL_R, S_MUL_B: begin
          if (w_mul_last) begin
            r_p <= '0;
            r_k <= '0;
            if (r_state == S_MUL_R) begin
              r_racc <= w_p_nx[WIDTH-1:0];
            end else begin
              r_bacc <= w_p_nx[WIDTH-1:0];
              if (r_j != c_j_last) r_j <= r_j + JW'(1);
            end
          end else begin
            r_p <= w_p_nx[WIDTH-1:0];
            r_k <= r_k + JW'(1);
          end
        end
        S_FIN:   r_result <= r_racc;
        default: ;
      endcase
    end
  end

  // ---------------- software-visible registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
    end else begin
      if (w_wr_ok & w_hit_ctrl & be_i[0]) r_irq_en <= wdata_i[1];
      if (w_wr_ok & (w_idx == c_idx_base)) r_base <= w_wmerged[WIDTH-1:0];
      if (w_wr_ok & (w_idx == c_idx_exp))  r_exp  <= w_wmerged[WIDTH-1:0];
      if (w_wr_ok & (w_idx == c_idx_mod))  r_mod  <= w_wmerged[WIDTH-1:0];

      if (w_set_done)                   r_done <= 1'b1;
      else if (w_start | w_clr_done)    r_done <= 1'b0;
      if (w_set_err)                    r_err  <= 1'b1;
      else if (w_start | w_clr_err)     r_err  <= 1'b0;

      r_irq <= r_done & r_irq_en;
    end
  end

`ifdef DH_CYCLE_COUNTER_EN
  // The START cycle itself is counted, so the final value equals START-to-DONE latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_cycles <= '0;
    else if (w_start) r_cycles <= 64'd1;
    else if (w_busy)  r_cycles <= r_cycles + 64'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dh_modexp_slave.sv
`default_nettype none
// tb_dh_modexp_slave: directed register-level checks of the DH modexp responder.
module tb_dh_modexp_slave;

  localparam logic [15:0] c_ctrl   = 16'h0000;
  localparam logic [15:0] c_status = 16'h0008;
  localparam logic [15:0] c_base   = 16'h0010;
  localparam logic [15:0] c_exp    = 16'h0018;
  localparam logic [15:0] c_mod    = 16'h0020;
  localparam logic [15:0] c_result = 16'h0028;
  localparam logic [15:0] c_cycles = 16'h0030;
  localparam logic [15:0] c_hole   = 16'h0040;
  localparam int          c_poll_max = 6000;

  logic        clk, rst_n;
  logic        req, we, gnt, rvalid, err, irq;
  logic [15:0] addr;
  logic [63:0] wdata, rdata;
  logic [7:0]  be;

  int n_pass  = 0;
  int n_total = 0;

  dh_modexp_slave #(.WIDTH(64), .ADDR_W(16)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // One access per clock: drive on the falling edge, sample the response 1ns after the next rise.
  task automatic access(input logic w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] b, output logic [63:0] rd_v, output logic er);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    chk("gnt", 64'(gnt), 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    chk("rvalid", 64'(rvalid), 64'd1);
    rd_v = rdata;
    er   = err;
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [63:0] d,
                    input logic [7:0] b, input logic exp_err);
    logic [63:0] rd_v;
    logic        e;
    access(1'b1, a, d, b, rd_v, e);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
    chk({tag, "_wrdata"}, rd_v, 64'd0);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [63:0] exp_v,
                    input logic exp_err);
    logic [63:0] rd_v;
    logic        e;
    access(1'b0, a, 64'd0, 8'h00, rd_v, e);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
    chk(tag, rd_v, exp_v);
  endtask

  // Reads STATUS every cycle; n is the index of the first read that shows DONE.
  task automatic poll_done(output int n, output logic [63:0] first_st, output logic [63:0] last_st);
    logic [63:0] d;
    logic        e;
    n = 0;
    first_st = '0;
    do begin
      n++;
      access(1'b0, c_status, 64'd0, 8'h00, d, e);
      if (n == 1) first_st = d;
    end while (!d[1] && n < c_poll_max);
    last_st = d;
    chk("poll_timeout", 64'(n < c_poll_max), 64'd1);
  endtask

  initial begin
    int          n;
    logic [63:0] st0, st1;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rd("rst_ctrl", c_ctrl, 64'd0, 1'b0);
    rd("rst_status", c_status, 64'd0, 1'b0);
    rd("rst_base", c_base, 64'd0, 1'b0);
    rd("rst_exp", c_exp, 64'd0, 1'b0);
    rd("rst_mod", c_mod, 64'd0, 1'b0);
    rd("rst_result", c_result, 64'd0, 1'b0);

    // Byte enables and unmapped offsets
    wr("base_full", c_base, 64'h1122334455667788, 8'hFF, 1'b0);
    wr("base_be01", c_base, 64'h00000000000000FF, 8'h01, 1'b0);
    rd("base_be", c_base, 64'h11223344556677FF, 1'b0);
    wr("base_be80", c_base, 64'hAB00000000000000, 8'h80, 1'b0);
    rd("base_be_hi", c_base, 64'hAB223344556677FF, 1'b0);
    rd("hole_rd", c_hole, 64'd0, 1'b1);
    wr("hole_wr", c_hole, 64'hFFFF, 8'hFF, 1'b1);

    // 5^3 mod 13 = 8, exact latency
    wr("b1", c_base, 64'd5, 8'hFF, 1'b0);
    wr("e1", c_exp, 64'd3, 8'hFF, 1'b0);
    wr("m1", c_mod, 64'd13, 8'hFF, 1'b0);
    wr("start1", c_ctrl, 64'h3, 8'hFF, 1'b0);
    poll_done(n, st0, st1);
    chk("busy1", st0[0], 64'd1);
    chk("lat1", 64'(n), 64'd4291);
    rd("res1", c_result, 64'd8, 1'b0);
    rd("status1", c_status, 64'h2, 1'b0);
    chk("irq1", 64'(irq), 64'd1);
    rd("ctrl_rb", c_ctrl, 64'h2, 1'b0);
`ifdef DH_CYCLE_COUNTER_EN
    rd("cycles1", c_cycles, 64'd4291, 1'b0);
`else
    rd("cycles_unmapped", c_cycles, 64'd0, 1'b1);
`endif
    wr("res_ro", c_result, 64'hFF, 8'hFF, 1'b0);
    rd("res_ro_rb", c_result, 64'd8, 1'b0);
    wr("w1c_done", c_status, 64'h2, 8'hFF, 1'b0);
    rd("status_clr", c_status, 64'h0, 1'b0);
    chk("irq_clr", 64'(irq), 64'd0);

    // 2^10 mod 1000 = 24, with rejected accesses while busy
    wr("b2", c_base, 64'd2, 8'hFF, 1'b0);
    wr("e2", c_exp, 64'd10, 8'hFF, 1'b0);
    wr("m2", c_mod, 64'd1000, 8'hFF, 1'b0);
    wr("start2", c_ctrl, 64'h3, 8'hFF, 1'b0);
    wr("exp_busy", c_exp, 64'd7, 8'hFF, 1'b1);
    wr("start_busy", c_ctrl, 64'h3, 8'hFF, 1'b1);
    rd("exp_keep", c_exp, 64'd10, 1'b0);
    rd("status_busy", c_status, 64'h1, 1'b0);
    poll_done(n, st0, st1);
    chk("done2", st1, 64'h2);
    rd("res2", c_result, 64'd24, 1'b0);

    // Modulus of one gives a zero result
    wr("b3", c_base, 64'd0, 8'hFF, 1'b0);
    wr("e3", c_exp, 64'd5, 8'hFF, 1'b0);
    wr("m3", c_mod, 64'd1, 8'hFF, 1'b0);
    wr("start3", c_ctrl, 64'h3, 8'hFF, 1'b0);
    poll_done(n, st0, st1);
    chk("done3", st1, 64'h2);
    rd("res3", c_result, 64'd0, 1'b0);

    // EXP = 0 gives 1; latency 2 + 64*65 + 0 + 1
    wr("b4", c_base, 64'd3, 8'hFF, 1'b0);
    wr("e4", c_exp, 64'd0, 8'hFF, 1'b0);
    wr("m4", c_mod, 64'd7, 8'hFF, 1'b0);
    wr("start4", c_ctrl, 64'h3, 8'hFF, 1'b0);
    poll_done(n, st0, st1);
    chk("lat4", 64'(n), 64'd4163);
    rd("res4", c_result, 64'd1, 1'b0);

    // Zero modulus error path
    wr("m5", c_mod, 64'd0, 8'hFF, 1'b0);
    wr("start5", c_ctrl, 64'h3, 8'hFF, 1'b0);
    poll_done(n, st0, st1);
    chk("lat5", 64'(n), 64'd2);
    chk("status5", st1, 64'h6);
    rd("res5", c_result, 64'd0, 1'b0);

    // BASE >= MOD error path
    wr("b6", c_base, 64'd20, 8'hFF, 1'b0);
    wr("m6", c_mod, 64'd13, 8'hFF, 1'b0);
    wr("start6", c_ctrl, 64'h3, 8'hFF, 1'b0);
    poll_done(n, st0, st1);
    chk("lat6", 64'(n), 64'd2);
    chk("status6", st1, 64'h6);
    wr("w1c_err", c_status, 64'h4, 8'hFF, 1'b0);
    rd("status6_clr", c_status, 64'h2, 1'b0);

    // Asynchronous reset in the middle of a run
    wr("b7", c_base, 64'd5, 8'hFF, 1'b0);
    wr("e7", c_exp, 64'd3, 8'hFF, 1'b0);
    wr("start7", c_ctrl, 64'h3, 8'hFF, 1'b0);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_irq", 64'(irq), 64'd0);
    chk("rst2_rvalid", 64'(rvalid), 64'd0);
    rd("rst2_status", c_status, 64'd0, 1'b0);
    rd("rst2_ctrl", c_ctrl, 64'd0, 1'b0);
    rd("rst2_base", c_base, 64'd0, 1'b0);
    rd("rst2_mod", c_mod, 64'd0, 1'b0);
    rd("rst2_result", c_result, 64'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
